// File: rtl/dm_access_unit.sv
// Data-memory access stage: turns a decoded load/store into a single word-wide,
// byte-enabled memory transaction and returns extended load data or an error.
module dm_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_dmtype,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic              m_ready,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    localparam logic [8:0] TMO = 9'(TIMEOUT);

    state_t            state_q, state_d;
    logic [2:0]        dmtype_q, dmtype_d;
    logic [1:0]        lane_q, lane_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [3:0]        m_be_q, m_be_d;
    logic [31:0]       m_wdata_q, m_wdata_d;

    logic        bad;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;
    logic [8:0]  cnt_inc;
    logic        tmo_hit;

    // Request decode: alignment/legality check and store-lane formatting.
    always_comb begin
        bad     = 1'b0;
        st_be   = 4'b1111;
        st_data = cpu_wdata;
        case (cpu_dmtype)
            3'b000: bad = (cpu_addr[1:0] != 2'b00);
            3'b001, 3'b010: begin
                bad     = cpu_addr[0];
                st_be   = cpu_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {cpu_wdata[15:0], cpu_wdata[15:0]};
            end
            3'b011, 3'b100: begin
                st_be   = 4'b0001 << cpu_addr[1:0];
                st_data = {4{cpu_wdata[7:0]}};
            end
            default: bad = 1'b1;
        endcase
    end

    // Load extraction uses the lane and size latched at accept time.
    always_comb begin
        ld_shift = m_rdata >> {lane_q, 3'b000};
        case (dmtype_q)
            3'b000:  ld_ext = m_rdata;
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_ext = {16'h0000, ld_shift[15:0]};
            3'b011:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_ext = {24'h000000, ld_shift[7:0]};
            default: ld_ext = 32'h0;
        endcase
    end

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;
    assign tmo_hit = (cnt_inc == TMO);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cpu_req) state_d = bad ? S_DONE : S_BUS;
            S_BUS:   if (m_ready || tmo_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_stall = ((state_q == S_IDLE) && cpu_req) || (state_q == S_BUS);
        cpu_done  = (state_q == S_DONE);
        cpu_err   = err_q;
        cpu_rdata = rdata_q;
        m_req     = m_req_q;
        m_we      = m_we_q;
        m_addr    = m_addr_q;
        m_be      = m_be_q;
        m_wdata   = m_wdata_q;
    end

    // Datapath next-state; all memory fields stay frozen while in BUS.
    always_comb begin
        dmtype_d  = dmtype_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_be_d    = m_be_q;
        m_wdata_d = m_wdata_q;
        case (state_q)
            S_IDLE: if (cpu_req) begin
                dmtype_d = cpu_dmtype;
                lane_d   = cpu_addr[1:0];
                cnt_d    = 8'd0;
                if (bad) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    err_d     = 1'b0;
                    m_req_d   = 1'b1;
                    m_we_d    = cpu_we;
                    m_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                    m_be_d    = cpu_we ? st_be : 4'b1111;
                    m_wdata_d = st_data;
                end
            end
            S_BUS: begin
                if (m_ready) begin
                    m_req_d = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = ld_ext;
                end else if (tmo_hit) begin
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmtype_q  <= 3'b000;
            lane_q    <= 2'b00;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_be_q    <= 4'b0000;
            m_wdata_q <= 32'h0;
        end else begin
            dmtype_q  <= dmtype_d;
            lane_q    <= lane_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_be_q    <= m_be_d;
            m_wdata_q <= m_wdata_d;
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: stores, loads, errors, timeout and reset abort.
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_dmtype = 3'b000;
    logic [31:0] cpu_addr = 32'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_stall, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    int n_cmp = 0;
    int n_err = 0;

    dm_access_unit #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_dmtype(cpu_dmtype),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] dt, input logic [31:0] a, input logic [31:0] wd);
        cpu_req = 1'b1; cpu_we = we; cpu_dmtype = dt; cpu_addr = a; cpu_wdata = wd;
    endtask

    // Memory answers on the first BUS cycle.
    task automatic access(input string tag, input logic we, input logic [2:0] dt,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                          input logic [31:0] ea, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        @(negedge clk);
        drive(we, dt, a, wd);
        #1 chk({tag, ".stall_acc"}, 32'(cpu_stall), 32'd1);
        @(negedge clk);
        chk({tag, ".m_req"}, 32'(m_req), 32'd1);
        chk({tag, ".m_we"}, 32'(m_we), 32'(we));
        chk({tag, ".m_addr"}, m_addr, ea);
        chk({tag, ".m_be"}, 32'(m_be), 32'(ebe));
        if (we) chk({tag, ".m_wdata"}, m_wdata, ewd);
        chk({tag, ".stall_bus"}, 32'(cpu_stall), 32'd1);
        m_ready = 1'b1; m_rdata = mrd;
        @(negedge clk);
        m_ready = 1'b0; cpu_req = 1'b0;
        chk({tag, ".done"}, 32'(cpu_done), 32'd1);
        chk({tag, ".err"}, 32'(cpu_err), 32'd0);
        chk({tag, ".m_req_drop"}, 32'(m_req), 32'd0);
        #1 chk({tag, ".stall_done"}, 32'(cpu_stall), 32'd0);
        if (!we) chk({tag, ".rdata"}, cpu_rdata, erd);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(cpu_done), 32'd0);
    endtask

    task automatic bad_access(input string tag, input logic [2:0] dt, input logic [31:0] a);
        @(negedge clk);
        drive(1'b0, dt, a, 32'h0);
        @(negedge clk);
        cpu_req = 1'b0;
        chk({tag, ".m_req"}, 32'(m_req), 32'd0);
        chk({tag, ".done"}, 32'(cpu_done), 32'd1);
        chk({tag, ".err"}, 32'(cpu_err), 32'd1);
        chk({tag, ".rdata"}, cpu_rdata, 32'h0);
        @(negedge clk);
        chk({tag, ".m_req2"}, 32'(m_req), 32'd0);
        chk({tag, ".done_pulse"}, 32'(cpu_done), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.m_req", 32'(m_req), 32'd0);
        chk("rst.m_we", 32'(m_we), 32'd0);
        chk("rst.m_addr", m_addr, 32'h0);
        chk("rst.m_be", 32'(m_be), 32'd0);
        chk("rst.m_wdata", m_wdata, 32'h0);
        chk("rst.done", 32'(cpu_done), 32'd0);
        chk("rst.err", 32'(cpu_err), 32'd0);
        chk("rst.rdata", cpu_rdata, 32'h0);
        chk("rst.stall", 32'(cpu_stall), 32'd0);
        rst = 1'b0;

        access("sw",  1'b1, 3'b000, 32'h100, 32'hDEADBEEF, 32'h0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
        access("lb",  1'b0, 3'b011, 32'h203, 32'h0, 32'h80FF_0000, 32'h200, 4'b1111, 32'h0, 32'hFFFFFF80);
        access("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 32'h200, 4'b1111, 32'h0, 32'h00000080);
        access("sh",  1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 32'h300, 4'b1100, 32'hABCDABCD, 32'h0);
        access("sh0", 1'b1, 3'b010, 32'h300, 32'h1234ABCD, 32'h0, 32'h300, 4'b0011, 32'hABCDABCD, 32'h0);
        access("sb",  1'b1, 3'b011, 32'h201, 32'h00000055, 32'h0, 32'h200, 4'b0010, 32'h55555555, 32'h0);
        access("lh",  1'b0, 3'b001, 32'h302, 32'h0, 32'h8001_7FFF, 32'h300, 4'b1111, 32'h0, 32'hFFFF8001);
        access("lhu", 1'b0, 3'b010, 32'h300, 32'h0, 32'h8001_7FFF, 32'h300, 4'b1111, 32'h0, 32'h00007FFF);
        access("lb1", 1'b0, 3'b011, 32'h201, 32'h0, 32'h1234_7F56, 32'h200, 4'b1111, 32'h0, 32'h0000007F);

        bad_access("mis_w", 3'b000, 32'h101);
        bad_access("mis_h", 3'b001, 32'h301);
        bad_access("bad_dt", 3'b110, 32'h100);

        // Memory never answers: request must last exactly 4 cycles.
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h400, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("tmo.m_req%0d", i), 32'(m_req), 32'd1);
            chk($sformatf("tmo.done%0d", i), 32'(cpu_done), 32'd0);
        end
        @(negedge clk);
        cpu_req = 1'b0;
        chk("tmo.m_req_drop", 32'(m_req), 32'd0);
        chk("tmo.done", 32'(cpu_done), 32'd1);
        chk("tmo.err", 32'(cpu_err), 32'd1);
        chk("tmo.rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        m_ready = 1'b1; m_rdata = 32'h1111_2222;
        @(negedge clk);
        m_ready = 1'b0;
        chk("idle_rdy.m_req", 32'(m_req), 32'd0);
        chk("idle_rdy.done", 32'(cpu_done), 32'd0);
        chk("idle_rdy.rdata", cpu_rdata, 32'h0);

        // Reset during the second BUS cycle abandons the access.
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h500, 32'h0);
        @(negedge clk);
        chk("rstbus.m_req1", 32'(m_req), 32'd1);
        @(negedge clk);
        chk("rstbus.m_req2", 32'(m_req), 32'd1);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstbus.m_req", 32'(m_req), 32'd0);
        chk("rstbus.done", 32'(cpu_done), 32'd0);
        chk("rstbus.stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        chk("rstbus.done2", 32'(cpu_done), 32'd0);
        access("lw", 1'b0, 3'b000, 32'h500, 32'h0, 32'hCAFEF00D, 32'h500, 4'b1111, 32'h0, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Data-memory access stage downstream of the instruction decoder.
- Consumes the decoded MemWrite/WDSel-style load/store intent, DMType size code, effective address and store data from the datapath.
- Drives a word-wide, byte-enabled memory port through a valid/ready handshake.
- Stalls the core until the access completes, then returns the aligned, sign- or zero-extended load data or an error flag.

Parameters:
- TIMEOUT, 255: max cycles the memory may take to answer m_ready before the access aborts with error; range 1..255.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  load or store request; fields below held stable while cpu_stall=1.
- cpu_we  in  1  1=store, 0=load.
- cpu_dmtype  in  3  000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_stall  out  1  hold the core.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  extended load data; valid when cpu_done=1 and cpu_we was 0.
- cpu_err  out  1  with cpu_done: misaligned, illegal dmtype, or timeout.
- m_req  out  1  memory request, registered.
- m_we  out  1  memory write.
- m_addr  out  ADDR_W  word-aligned address, low 2 bits 0.
- m_be  out  4  byte enables.
- m_wdata  out  32  lane-replicated store data.
- m_ready  in  1  memory accepts/completes this cycle.
- m_rdata  in  32  read word; valid when m_ready=1.

Behaviour:
- Reset values: state IDLE; m_req=0, m_we=0, m_addr=0, m_be=0, m_wdata=0, cpu_done=0, cpu_err=0, cpu_rdata=0, timeout counter 0.
- States: IDLE, BUS, DONE.
- cpu_stall = (IDLE & cpu_req) | BUS. It is combinational and is 0 in DONE.
- IDLE with cpu_req=1: latch we, dmtype, addr[1:0] and formatted store data.
  - Misaligned (word with addr[1:0]!=0, half with addr[0]!=0) or dmtype 101..111 -> DONE with err=1; no memory cycle is issued.
  - Otherwise -> BUS with m_req=1 registered; m_addr = {addr[ADDR_W-1:2],2'b00}.
- BUS: hold m_req and all m_* fields stable until m_ready=1.
  - On m_ready: capture m_rdata, drop m_req next cycle, go to DONE with err=0.
  - Counter increments each BUS cycle without m_ready. On reaching TIMEOUT: drop m_req, go to DONE with err=1, cpu_rdata=0.
- DONE: cpu_done=1 for exactly one cycle, then IDLE. A cpu_req present in DONE is not accepted until the following IDLE cycle.
- Minimum latency with m_ready returned in the first BUS cycle: accept cycle, BUS cycle, DONE cycle (3 cycles with stall high for 2).
- Store formatting:
  - word: be=1111, data unchanged.
  - half: data {w[15:0],w[15:0]}; be=0011 if addr[1]=0, 1100 otherwise.
  - byte: w[7:0] replicated ×4; be=0001<<addr[1:0].
  - Unsigned codes on stores behave as their signed sizes.
- Load extraction: select the lane by the latched addr[1:0].
  - Half/byte are sign-extended; unsigned variants are zero-extended.
  - m_be=1111 on all loads; m_we=0.
- cpu_rdata is held until the next DONE; cpu_err is only meaningful while cpu_done=1.
- rst asserted in any state, including mid-BUS: next cycle IDLE, m_req=0, in-flight access abandoned, no cpu_done.
- m_ready while not in BUS is ignored.

Test Plan:
- Word store: addr 0x100, wdata 0xDEADBEEF -> m_addr 0x100, be 1111, m_wdata 0xDEADBEEF; m_ready on 1st BUS cycle -> cpu_done 2 cycles after accept, err=0.
- Byte loads: addr 0x203, m_rdata 0x80FF_0000. Signed (011) -> rdata 0xFFFFFF80; unsigned (100) -> 0x00000080; be 1111, m_addr 0x200.
- Half store: addr 0x302, wdata 0x1234ABCD -> be 1100, m_wdata 0xABCDABCD. Half load at addr 0x302 with m_rdata 0x8001_7FFF -> 0xFFFF8001.
- Misaligned word at 0x101 and dmtype 110 -> no m_req ever asserted, cpu_done + cpu_err=1 in the cycle after accept.
- TIMEOUT=4, m_ready held 0 -> m_req high exactly 4 cycles, then cpu_done + cpu_err=1. Then m_ready pulsed in IDLE -> ignored.
- rst asserted in 2nd BUS cycle -> m_req=0 next cycle, no cpu_done; a new word load then completes normally.
